// File: rtl/capp_tag_sequencer.sv
// capp_tag_sequencer: one-at-a-time command sequencer for the CAPP tag array.
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   cmd_valid/cmd_op/cmd_ready      command port (00 SET, 01 SEARCH, 10 FIRST, 11 ENUM)
//   tag_wires                       tag vector read back from the array
//   set/search_en/select_first      one-cycle control strobes to the array
//   resp_valid/resp_index/resp_last/resp_ready  responder index stream
//   resp_count, some_none, busy, done           status
module capp_tag_sequencer #(
  parameter int num_cells = 100,
  parameter int SETTLE = 2,
  parameter int IDX_W = (num_cells > 1) ? $clog2(num_cells) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  output logic                 cmd_ready,
  input  logic [num_cells-1:0] tag_wires,
  output logic                 set,
  output logic                 search_en,
  output logic                 select_first,
  output logic                 resp_valid,
  output logic [IDX_W-1:0]     resp_index,
  output logic                 resp_last,
  input  logic                 resp_ready,
  output logic [IDX_W:0]       resp_count,
  output logic                 some_none,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  typedef enum logic [2:0] {
    IDLE, S_SET, S_SEARCH, S_WAIT, S_SELECT, S_CAPTURE, S_OUT, S_DONE
  } state_t;
  state_t               state_q, state_d;
  logic [num_cells-1:0] shadow_q, shadow_d, rest;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IDX_W:0]       count_q, count_d;
  logic [IDX_W-1:0]     low;
  logic                 out;
  // rest is shadow with its lowest set bit cleared; zero means one responder left
  assign rest         = shadow_q & (shadow_q - num_cells'(1));
  assign out          = state_q == S_OUT;
  assign cmd_ready    = state_q == IDLE && !RST;
  assign set          = state_q == S_SET;
  assign search_en    = state_q == S_SEARCH;
  assign select_first = state_q == S_SELECT;
  assign resp_valid   = out;
  assign resp_index   = out ? low : '0;
  assign resp_last    = out && rest == '0;
  assign resp_count   = count_q;
  assign some_none    = |shadow_q;
  assign busy         = state_q != IDLE;
  assign done         = state_q == S_DONE;
  always_comb begin
    low = '0;
    for (int i = num_cells - 1; i >= 0; i--)
      if (shadow_q[i]) low = IDX_W'(i);
  end
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        count_d = '0;
        state_d = cmd_op == 2'b00 ? S_SET :
                  cmd_op == 2'b01 ? S_SEARCH :
                  cmd_op == 2'b10 ? S_SELECT : S_CAPTURE;
      end
      S_SET:    state_d = S_DONE;
      S_SEARCH: begin
        cnt_d   = CW'(SETTLE - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        state_d = cnt_q == '0 ? S_DONE : S_WAIT;
      end
      S_SELECT: state_d = S_CAPTURE;
      S_CAPTURE: begin
        shadow_d = tag_wires;
        state_d  = |tag_wires ? S_OUT : S_DONE;
      end
      S_OUT: if (resp_ready) begin
        shadow_d = rest;
        count_d  = count_q + (IDX_W+1)'(1);
        state_d  = rest == '0 ? S_DONE : S_OUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_capp_tag_sequencer.sv
// tb_capp_tag_sequencer: directed self-checking bench for capp_tag_sequencer.
module tb_capp_tag_sequencer;
  logic        CLK = 0;
  logic        RST = 1;
  logic        cmd_valid = 0;
  logic [1:0]  cmd_op = 0;
  logic        cmd_ready;
  logic [99:0] tag_wires = '0;
  logic        set, search_en, select_first;
  logic        resp_valid, resp_last;
  logic        resp_ready = 0;
  logic [6:0]  resp_index;
  logic [7:0]  resp_count;
  logic        some_none, busy, done;
  int          checks = 0;
  int          errors = 0;
  capp_tag_sequencer dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .tag_wires(tag_wires), .set(set), .search_en(search_en), .select_first(select_first),
    .resp_valid(resp_valid), .resp_index(resp_index), .resp_last(resp_last),
    .resp_ready(resp_ready), .resp_count(resp_count), .some_none(some_none),
    .busy(busy), .done(done)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic issue(input logic [1:0] op);
    cmd_valid = 1;
    cmd_op = op;
    step();
    cmd_valid = 0;
    cmd_op = 0;
  endtask
  task automatic resp(input string tag, input logic [6:0] idx, input logic last);
    chk({tag, "_valid"}, resp_valid, 1);
    chk({tag, "_index"}, resp_index, idx);
    chk({tag, "_last"}, resp_last, last);
  endtask
  task automatic set_scenario(input string tag);
    chk({tag, "_ready_before"}, cmd_ready, 1);
    issue(2'b00);
    chk({tag, "_set_t1"}, set, 1);
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_ready_t1"}, cmd_ready, 0);
    chk({tag, "_done_t1"}, done, 0);
    step();
    chk({tag, "_set_t2"}, set, 0);
    chk({tag, "_done_t2"}, done, 1);
    chk({tag, "_busy_t2"}, busy, 1);
    step();
    chk({tag, "_ready_t3"}, cmd_ready, 1);
    chk({tag, "_busy_t3"}, busy, 0);
    chk({tag, "_done_t3"}, done, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_count", resp_count, 0);
    RST = 0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    set_scenario("set1");
    issue(2'b01);
    chk("srch_en_t1", search_en, 1);
    step();
    chk("srch_en_t2", search_en, 0);
    chk("srch_done_t2", done, 0);
    step();
    chk("srch_done_t3", done, 0);
    chk("srch_valid_t3", resp_valid, 0);
    step();
    chk("srch_done_t4", done, 1);
    step();
    chk("srch_idle", cmd_ready, 1);
    tag_wires = 100'h25;
    resp_ready = 1;
    issue(2'b11);
    chk("enum_cap_valid", resp_valid, 0);
    chk("enum_cap_busy", busy, 1);
    step();
    resp("enum_r0", 7'd0, 0);
    chk("enum_some", some_none, 1);
    step();
    resp("enum_r1", 7'd2, 0);
    step();
    resp("enum_r2", 7'd5, 1);
    step();
    chk("enum_done", done, 1);
    chk("enum_valid_off", resp_valid, 0);
    chk("enum_count", resp_count, 3);
    chk("enum_some_end", some_none, 0);
    step();
    resp_ready = 0;
    issue(2'b11);
    step();
    resp("stall_a0", 7'd0, 0);
    step();
    resp("stall_a1", 7'd0, 0);
    resp_ready = 1;
    step();
    resp("stall_b0", 7'd2, 0);
    resp_ready = 0;
    tag_wires = '0;
    step();
    resp("stall_b1", 7'd2, 0);
    resp_ready = 1;
    step();
    resp("stall_c0", 7'd5, 1);
    resp_ready = 0;
    step();
    resp("stall_c1", 7'd5, 1);
    chk("stall_count_mid", resp_count, 2);
    resp_ready = 1;
    step();
    chk("stall_done", done, 1);
    chk("stall_count", resp_count, 3);
    step();
    tag_wires = '0;
    tag_wires[63] = 1'b1;
    issue(2'b10);
    chk("first_sel_t1", select_first, 1);
    step();
    chk("first_sel_t2", select_first, 0);
    chk("first_valid_t2", resp_valid, 0);
    step();
    resp("first63", 7'd63, 1);
    step();
    chk("first_done", done, 1);
    chk("first_count", resp_count, 1);
    step();
    tag_wires = '0;
    issue(2'b10);
    chk("fz_sel", select_first, 1);
    step();
    step();
    chk("fz_done", done, 1);
    chk("fz_valid", resp_valid, 0);
    chk("fz_count", resp_count, 0);
    step();
    tag_wires = '0;
    tag_wires[99] = 1'b1;
    issue(2'b11);
    step();
    resp("top99", 7'd99, 1);
    step();
    chk("top99_done", done, 1);
    step();
    tag_wires = 100'h25;
    issue(2'b11);
    step();
    resp("abort_r0", 7'd0, 0);
    RST = 1;
    step();
    chk("abort_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_count", resp_count, 0);
    chk("abort_some", some_none, 0);
    chk("abort_index", resp_index, 0);
    RST = 0;
    step();
    chk("abort_no_done", done, 0);
    set_scenario("set2");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/capp_tag_sequencer.md
# capp_tag_sequencer

Command sequencer for the CAPP tag register array. It accepts one operation at a time over a valid/ready command port and drives the array's control strobes (`set`, `search_en`, `select_first`). After a selection or enumeration it reads the array's tag vector and streams the indices of the responders out over a valid/ready response port. It sits between the host/microcode issue logic and the tag array, and is the only block that drives the array's control inputs.

## Interface
- `num_cells`, default 100: number of cells and tag bits.
- `SETTLE`, default 2: wait cycles after `search_en` before the match lines and tags are valid (≥1).
- `IDX_W`, derived as max(1, $clog2(num_cells)): index width.
- Clock and reset: one clock; reset is synchronous and active-high.
  - `CLK` in, 1: rising-edge clock.
  - `RST` in, 1: synchronous, active-high reset.
- Command port:
  - `cmd_valid` in, 1: command offered.
  - `cmd_op` in, 2: 00 SET, 01 SEARCH, 10 FIRST, 11 ENUM.
  - `cmd_ready` out, 1: high only in IDLE.
- Tag array connections:
  - `tag_wires` in, num_cells: current tag register vector from the array.
  - `set` out, 1: one-cycle pulse; array sets all tags.
  - `search_en` out, 1: one-cycle pulse; array compares and clears non-matching tags.
  - `select_first` out, 1: one-cycle pulse; array keeps only the lowest set tag.
- Response port:
  - `resp_valid` out, 1: responder index offered.
  - `resp_index` out, IDX_W: index of the responder.
  - `resp_last` out, 1: this is the final responder of the operation.
  - `resp_ready` in, 1: consumer accepts the response.
- Status:
  - `resp_count` out, IDX_W+1: responses delivered in the current or last operation.
  - `some_none` out, 1: OR of the shadow tag copy (any responder remaining).
  - `busy` out, 1: FSM is not in IDLE.
  - `done` out, 1: one-cycle pulse when an operation completes.

## Operation
- States:
  - IDLE, S_SET, S_SEARCH, S_WAIT, S_SELECT: strobe and settle sequencing.
  - S_CAPTURE, S_OUT, S_DONE: tag capture, response streaming and completion.
- IDLE:
  - `cmd_ready`=1.
  - Acceptance happens on `cmd_valid && cmd_ready`. It clears `resp_count` and branches on `cmd_op`.
  - Idle-cycle `cmd_op` values are ignored.
- SET: S_SET asserts `set` → S_DONE.
- SEARCH:
  - S_SEARCH asserts `search_en`.
  - Then S_WAIT for exactly SETTLE cycles, using an internal counter → S_DONE.
- FIRST: S_SELECT asserts `select_first` → S_CAPTURE.
- ENUM: goes directly to S_CAPTURE.
- S_CAPTURE:
  - `shadow <= tag_wires`.
  - Next state is S_OUT if the captured value is nonzero, else S_DONE.
- S_OUT:
  - `resp_valid`=1.
  - `resp_index` = lowest set bit of `shadow`.
  - `resp_last` = `shadow` has exactly one bit set.
  - On handshake: clear that bit in `shadow` and increment `resp_count`. If `resp_last`, go to S_DONE; else stay in S_OUT.
  - FIRST after a correct `select_first` yields one response. If the array returns more than one bit, all are enumerated anyway; the sequencer does not filter.
- S_DONE: `done`=1 for one cycle → IDLE.
- Arithmetic: `resp_count` cannot overflow, since its maximum is num_cells and it is IDX_W+1 bits wide.
- The strobes are mutually exclusive; at most one of `set`/`search_en`/`select_first` is high in any cycle.
- `shadow` persists after an operation; `some_none` reflects it until the next capture.

## Timing
- Let T = command acceptance edge cycle. Cycle-level sequence per operation:
  - SET: `set` high T+1; `done` T+2.
  - SEARCH: `search_en` high T+1; wait T+2..T+1+SETTLE; `done` T+2+SETTLE.
  - FIRST: `select_first` T+1; capture T+2; `resp_valid` from T+3 (or `done` T+3 if empty).
  - ENUM: capture T+1; `resp_valid` from T+2 (or `done` T+2 if empty).
- Response stream:
  - After a non-last handshake, the next index is valid the very next cycle, so one response per cycle with `resp_ready` held high.
  - `done` comes one cycle after the last handshake.
- `cmd_ready` returns the cycle after `done`, i.e. back-to-back commands cost one extra IDLE cycle.
- Response stability: while `resp_valid && !resp_ready`, `resp_index` and `resp_last` are held stable.
- Reset values, taking effect at the next edge:
  - All outputs, `shadow`, and the counters are 0; FSM in IDLE.
  - This applies even mid-operation, including mid-stream with `resp_valid` high. No `done` is issued for the aborted operation.
  - `cmd_ready`=0 while `RST`=1, and 1 in the first cycle after `RST` deasserts.
- Boundary conditions:
  - `tag_wires` changing during S_OUT is ignored; only the `shadow` copy is used.
  - Bit num_cells-1 set alone gives `resp_index`=num_cells-1 with `resp_last`=1.

## Test plan
- Reset, then SET (`cmd_op`=00) accepted at T → `set`=1 only at T+1, `done` at T+2, `cmd_ready`=1 at T+3, `busy` 1 at T+1..T+2.
- SEARCH with SETTLE=2 → `search_en` at T+1, `done` at T+4, no response traffic.
- ENUM with `tag_wires`=0x…0000_0025 (bits 0, 2, 5), `resp_ready`=1 → indices 0, 2, 5 at T+2..T+4, `resp_last` only on 5, `done` T+5, `resp_count`=3, `some_none`=0.
- ENUM with the same tags, `resp_ready` toggled 0/1 → each index held stable while stalled, same order, no duplicates or drops.
- FIRST with the array returning only bit 63 → `select_first` T+1, one response index 63 with `resp_last`=1. With all-zero tags instead, `done` at T+3, `resp_count`=0, no `resp_valid`.
- `RST` asserted mid-ENUM while `resp_valid`=1 → next cycle all outputs 0, no `done`; the subsequent SET behaves as in scenario 1.
